// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared definitions for the sprite mask fetch arbiter: sprite ids, mask ROM
// slot numbers, the default tile size, and small helpers used by the top.
package sprite_fetch_arbiter_pkg;

  localparam int TILE_SIZE_DEF = 16;
  localparam int NUM_SLOTS     = 14;
  localparam int NUM_REQ       = 4;

  typedef enum logic [3:0] {
    SPR_DOT     = 4'd0,
    SPR_BIG_DOT = 4'd1,
    SPR_PACMAN  = 4'd2,
    SPR_GHOST   = 4'd3,
    SPR_SCL_UP  = 4'd4,
    SPR_SCL_DN  = 4'd5,
    SPR_SCL_LT  = 4'd6,
    SPR_SCL_RT  = 4'd7,
    SPR_EYE_UP  = 4'd8,
    SPR_EYE_DN  = 4'd9,
    SPR_EYE_LT  = 4'd10,
    SPR_EYE_RT  = 4'd11
  } sprite_id_e;

  localparam logic [3:0] SLOT_DOT     = 4'd0;
  localparam logic [3:0] SLOT_BIG_DOT = 4'd1;
  localparam logic [3:0] SLOT_PACMAN  = 4'd2;  // +anim_frame
  localparam logic [3:0] SLOT_GHOST   = 4'd4;  // +anim_frame
  localparam logic [3:0] SLOT_SCLERA  = 4'd6;  // 6..9
  localparam logic [3:0] SLOT_EYE     = 4'd10; // 10..13

  typedef struct packed {
    logic       valid;
    logic [3:0] slot;
  } slot_t;

  // Ids 12..15 have no mask; they come back invalid so the ROM is not read.
  function automatic slot_t sprite_slot(input logic [3:0] id, input logic anim);
    slot_t s;
    s.valid = 1'b1;
    s.slot  = '0;
    case (id)
      SPR_DOT:     s.slot = SLOT_DOT;
      SPR_BIG_DOT: s.slot = SLOT_BIG_DOT;
      SPR_PACMAN:  s.slot = SLOT_PACMAN + {3'b000, anim};
      SPR_GHOST:   s.slot = SLOT_GHOST + {3'b000, anim};
      SPR_SCL_UP, SPR_SCL_DN, SPR_SCL_LT, SPR_SCL_RT:
                   s.slot = SLOT_SCLERA + {2'b00, id[1:0]};
      SPR_EYE_UP, SPR_EYE_DN, SPR_EYE_LT, SPR_EYE_RT:
                   s.slot = SLOT_EYE + {2'b00, id[1:0]};
      default:     s.valid = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Requester / mask ROM / response bundle for sprite_fetch_arbiter.
//   req, req_sprite, req_px : per-requester lookup (4 requesters)
//   gnt                     : one-hot grant pulse
//   rom_en, rom_addr        : mask ROM read, rom_data returns one cycle later
//   rsp_valid, rsp_id, rsp_bit : response strobe, requester index, mask bit
// slave = the arbiter, master = requesters plus ROM.
interface sprite_fetch_arbiter_if
  import sprite_fetch_arbiter_pkg::*;
#(
  parameter int TILE_SIZE = TILE_SIZE_DEF
);
  localparam int PXW = $clog2(TILE_SIZE * TILE_SIZE);

  logic [3:0]       req;
  logic [15:0]      req_sprite;
  logic [4*PXW-1:0] req_px;
  logic [3:0]       gnt;
  logic             rom_en;
  logic [4+PXW-1:0] rom_addr;
  logic             rom_data;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic             rsp_bit;

  modport slave (
    input  req, req_sprite, req_px, rom_data,
    output gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_bit
  );

  modport master (
    output req, req_sprite, req_px, rom_data,
    input  gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_bit
  );
endinterface

// File: rtl/sprite_fetch_arbiter_rr_arbiter4.sv
// Four-way round-robin grant, purely combinational.
//   req_i    : request vector
//   rr_ptr_i : index with highest priority this cycle
//   gnt_o    : one-hot grant (zero when no request)
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] rr_ptr_i,
  output logic [3:0] gnt_o
);
  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_i + 2'(i);  // wraps mod 4
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Sprite mask fetch arbiter: four requesters share one 1-bit mask ROM.
// A round-robin winner is granted each cycle, its sprite id is mapped to a
// ROM slot and {slot, px} is driven to the ROM; the bit returns as a response
// one cycle later.
//   clk, rst      : clock, asynchronous active-high reset
//   frame_tick    : video frame start pulse (drives the animation counter)
//   anim_frame    : current animation frame
//   bus (slave)   : request / grant / ROM / response bundle
// Build option: SPRITE_ANIM_EN enables the pacman/ghost animation counter;
// without it anim_frame is tied to 0 and frame_tick is ignored.
module sprite_fetch_arbiter
  import sprite_fetch_arbiter_pkg::*;
#(
  parameter int TILE_SIZE = TILE_SIZE_DEF,
  parameter int ANIM_DIV  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  output logic                   anim_frame,
  sprite_fetch_arbiter_if.slave  bus
);
  localparam int         PXW       = $clog2(TILE_SIZE * TILE_SIZE);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  logic [1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]     arb_gnt;
  logic [1:0]     gnt_idx;
  logic           gnt_any;
  logic [3:0]     gnt_sprite;
  logic [PXW-1:0] gnt_px;
  slot_t          slot_info;
  logic           anim_q;
  logic           rsp_vld_q, rsp_en_q;
  logic [1:0]     rsp_id_q;

  rr_arbiter4 u_arb (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (arb_gnt)
  );

  // Grant-cycle outputs are combinational but forced quiet while in reset.
  always_comb begin
    gnt_idx    = oh2idx(arb_gnt);
    gnt_any    = (|arb_gnt) & ~rst;
    gnt_sprite = bus.req_sprite[4*gnt_idx +: 4];
    gnt_px     = bus.req_px[PXW*gnt_idx +: PXW];
    slot_info  = sprite_slot(gnt_sprite, anim_q);
    rr_ptr_d   = gnt_any ? gnt_idx + 2'd1 : rr_ptr_q;
  end

  assign bus.gnt      = gnt_any ? arb_gnt : 4'b0000;
  assign bus.rom_en   = gnt_any & slot_info.valid;
  assign bus.rom_addr = bus.rom_en ? {slot_info.slot, gnt_px} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_en_q  <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rsp_vld_q <= gnt_any;
      rsp_en_q  <= bus.rom_en;
      if (gnt_any) rsp_id_q <= gnt_idx;
    end
  end

  // rom_data is only meaningful when the ROM was actually read.
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_bit   = rsp_vld_q & rsp_en_q & bus.rom_data;

`ifdef SPRITE_ANIM_EN
  logic [7:0] tick_cnt_q;

  // Toggle lands after the tick edge, so a grant in the tick cycle sees the
  // old frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      anim_q     <= 1'b0;
    end else if (frame_tick) begin
      if (tick_cnt_q == ANIM_LAST) begin
        tick_cnt_q <= '0;
        anim_q     <= ~anim_q;
      end else begin
        tick_cnt_q <= tick_cnt_q + 8'd1;
      end
    end
  end
`else
  logic unused_cfg;
  assign anim_q     = 1'b0;
  assign unused_cfg = frame_tick ^ (^ANIM_LAST);
`endif

  assign anim_frame = anim_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
module tb_sprite_fetch_arbiter;
  import sprite_fetch_arbiter_pkg::*;

  localparam int TS  = 16;
  localparam int PXW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic anim_frame;

  sprite_fetch_arbiter_if #(.TILE_SIZE(TS)) bus ();

  sprite_fetch_arbiter #(.TILE_SIZE(TS), .ANIM_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .anim_frame (anim_frame),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic       b;
  } exp_t;
  exp_t sb[$];

  // animation model (ANIM_DIV = 2)
  logic exp_anim = 1'b0;
  int   tcnt = 0;

  function automatic logic rom_fn(input logic [11:0] a);
    return ^(a ^ (a >> 3));
  endfunction

  function automatic int exp_slot(input int id, input logic anim);
    if (id < 2)   return id;
    if (id == 2)  return 2 + int'(anim);
    if (id == 3)  return 4 + int'(anim);
    if (id < 12)  return id + 2;
    return -1;
  endfunction

  // ROM model: returns junk (1) when not enabled
  always @(posedge clk) bus.rom_data <= bus.rom_en ? rom_fn(bus.rom_addr) : 1'b1;

  // response scoreboard
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_id=%0d rsp_bit=%0d, required no response",
                 bus.rsp_id, bus.rsp_bit);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_bit} !== {e.id, e.b}) begin
          errors++;
          $display("FAIL rsp_data: got id=%0d bit=%0d, required id=%0d bit=%0d",
                   bus.rsp_id, bus.rsp_bit, e.id, e.b);
        end
      end
    end
  end

  task automatic model_tick(input logic t);
`ifdef SPRITE_ANIM_EN
    if (t) begin
      if (tcnt == 1) begin tcnt = 0; exp_anim = ~exp_anim; end
      else tcnt++;
    end
`else
    if (t) tcnt = 0;
`endif
  endtask

  task automatic drive(input logic [3:0] r, input logic [15:0] s,
                       input logic [31:0] p, input logic t);
    @(negedge clk);
    bus.req = r; bus.req_sprite = s; bus.req_px = p; frame_tick = t;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = '0; frame_tick = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    exp_anim = 1'b0; tcnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0;
    bus.req = 4'b1111; bus.req_sprite = 16'h3210; bus.req_px = 32'h04030201;
    @(negedge clk); #2;
    checks++;
    if (bus.gnt !== 4'b0 || bus.rom_en !== 1'b0 || bus.rom_addr !== 12'h0) begin
      errors++;
      $display("FAIL reset_req_side: gnt=%b rom_en=%b rom_addr=%h, required 0000/0/000",
               bus.gnt, bus.rom_en, bus.rom_addr);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_bit !== 1'b0 || anim_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_side: rsp_valid=%b rsp_id=%0d rsp_bit=%b anim=%b, required all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_bit, anim_frame);
    end
    bus.req = '0;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0001, 16'h0000, 32'h00000005, 1'b0);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.rom_en !== 1'b1 || bus.rom_addr !== 12'h005) begin
      errors++;
      $display("FAIL single_grant: gnt=%b rom_en=%b addr=%h, required 0001/1/005",
               bus.gnt, bus.rom_en, bus.rom_addr);
    end
    sb.push_back('{2'd0, rom_fn(12'h005)});
    drive(4'b0000, 16'h0000, 32'h0, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_latency: rsp_valid=%b rsp_id=%0d, required 1/0", bus.rsp_valid, bus.rsp_id);
    end
    checks++;
    if (bus.gnt !== 4'b0 || bus.rom_en !== 1'b0 || bus.rom_addr !== 12'h0) begin
      errors++;
      $display("FAIL idle_outputs: gnt=%b rom_en=%b addr=%h, required 0000/0/000",
               bus.gnt, bus.rom_en, bus.rom_addr);
    end
    drive(4'b0000, 16'h0000, 32'h0, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rsp: rsp_valid=%b, required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int spr[4] = '{2, 3, 5, 9};
    int px[4]  = '{3, 17, 200, 255};
    logic [15:0] s;
    logic [31:0] p;
    for (int j = 0; j < 4; j++) begin
      s[4*j +: 4] = 4'(spr[j]);
      p[8*j +: 8] = 8'(px[j]);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      int k;
      logic [11:0] ea;
      k = i % 4;
      drive(4'b1111, s, p, 1'b0);
      ea = {4'(exp_slot(spr[k], 1'b0)), 8'(px[k])};
      checks++;
      if (bus.gnt !== 4'(1 << k) || bus.rom_en !== 1'b1 || bus.rom_addr !== ea) begin
        errors++;
        $display("FAIL rr_grant[%0d]: gnt=%b addr=%h, required gnt=%b addr=%h",
                 i, bus.gnt, bus.rom_addr, 4'(1 << k), ea);
      end
      sb.push_back('{2'(k), rom_fn(ea)});
    end
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic test_anim();
`ifdef SPRITE_ANIM_EN
    int seq[5] = '{2, 2, 3, 3, 2};
`else
    int seq[5] = '{2, 2, 2, 2, 2};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic t;
      logic [11:0] ea;
      t = (i < 4);
      drive(4'b0001, 16'h0002, 32'h0, t);
      ea = {4'(seq[i]), 8'h00};
      checks++;
      if (bus.rom_addr !== ea || anim_frame !== exp_anim) begin
        errors++;
        $display("FAIL anim_slot[%0d]: addr=%h anim=%b, required addr=%h anim=%b",
                 i, bus.rom_addr, anim_frame, ea, exp_anim);
      end
      sb.push_back('{2'd0, rom_fn(ea)});
      model_tick(t);
    end
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic test_invalid();
    do_reset();
    drive(4'b0100, 16'h0D00, 32'h00070000, 1'b0);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.rom_en !== 1'b0) begin
      errors++;
      $display("FAIL invalid_id: gnt=%b rom_en=%b, required 0100/0", bus.gnt, bus.rom_en);
    end
    sb.push_back('{2'd2, 1'b0});
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b0000, 16'h0, 32'h0, 1'b1); model_tick(1'b1);
    drive(4'b0000, 16'h0, 32'h0, 1'b1); model_tick(1'b1);
    drive(4'b0010, 16'h0010, 32'h00000900, 1'b0);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL pre_reset_grant: gnt=%b, required 0010", bus.gnt);
    end
    sb.push_back('{2'd1, rom_fn({4'd1, 8'd9})});
    drive(4'b0001, 16'h0000, 32'h00000001, 1'b0);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL dropped_grant: gnt=%b, required 0001", bus.gnt);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    exp_anim = 1'b0; tcnt = 0;
    bus.req = 4'b0110; bus.req_sprite = 16'h0010; bus.req_px = 32'h00000B00;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || anim_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: rsp_valid=%b anim=%b, required 0/0", bus.rsp_valid, anim_frame);
    end
    checks++;
    if (bus.gnt !== 4'b0010 || bus.rom_addr !== {4'd1, 8'd11}) begin
      errors++;
      $display("FAIL post_reset_grant: gnt=%b addr=%h, required 0010/10b", bus.gnt, bus.rom_addr);
    end
    sb.push_back('{2'd1, rom_fn({4'd1, 8'd11})});
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic test_no_anim();
    logic [11:0] ea;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(4'b0000, 16'h0, 32'h0, 1'b1);
      if (anim_frame !== exp_anim) bad++;
      model_tick(1'b1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL anim_track: %0d cycles with wrong anim_frame, required 0", bad);
    end
`ifndef SPRITE_ANIM_EN
    checks++;
    if (anim_frame !== 1'b0) begin
      errors++;
      $display("FAIL anim_held: anim=%b, required 0", anim_frame);
    end
`endif
    drive(4'b1000, 16'h3000, 32'h2A000000, 1'b0);
    ea = {4'(exp_slot(3, exp_anim)), 8'd42};
    checks++;
    if (bus.gnt !== 4'b1000 || bus.rom_addr !== ea) begin
      errors++;
      $display("FAIL ghost_slot: gnt=%b addr=%h, required 1000/%h", bus.gnt, bus.rom_addr, ea);
    end
    sb.push_back('{2'd3, rom_fn(ea)});
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
  endtask

  initial begin
    bus.req = '0; bus.req_sprite = '0; bus.req_px = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_anim();
    test_invalid();
    test_reset_mid();
    test_no_anim();
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
    drive(4'b0000, 16'h0, 32'h0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp: %0d responses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_arbiter.md
SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 Parameter TILE_SIZE, default 16, sprite edge length in pixels; PXW = clog2(TILE_SIZE*TILE_SIZE).
REQ-002 Parameter ANIM_DIV, default 8, number of frame_tick pulses per animation frame toggle (range 1..255).
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  4  per-requester lookup request, held high until granted.
REQ-006 req_sprite  in  16  4-bit sprite id per requester i at [4i+:4].
REQ-007 req_px  in  4*PXW  pixel index (row*TILE_SIZE+col) per requester i.
REQ-008 gnt  out  4  one-hot grant pulse, one cycle.
REQ-009 frame_tick  in  1  one-cycle pulse at each video frame start.
REQ-010 anim_frame  out  1  current animation frame (0 = f1, 1 = f2).
REQ-011 rom_en  out  1  mask ROM read enable.
REQ-012 rom_addr  out  4+PXW  mask ROM address {slot[3:0], px}.
REQ-013 rom_data  in  1  mask ROM bit, valid one cycle after rom_en.
REQ-014 rsp_valid / rsp_id / rsp_bit  out  1 / 2 / 1  response strobe, requester index, mask bit.

Function
REQ-015 Sprite ids: 0 dot, 1 big_dot, 2 pacman, 3 ghost body, 4-7 sclera up/down/left/right, 8-11 eye up/down/left/right, 12-15 invalid.
REQ-016 Slot map: dot 0, big_dot 1, pacman 2+anim_frame, ghost 4+anim_frame, sclera 6-9, eye 10-13.
REQ-017 Arbitration is round-robin over req; one grant per cycle maximum; search starts at rr_ptr.
REQ-018 After a grant to requester k, rr_ptr = (k+1) mod 4; with no grant, rr_ptr is unchanged.
REQ-019 In the grant cycle the block drives gnt[k]=1, rom_en=1 and rom_addr={slot(k), req_px[k]}, all combinational from registered rr_ptr/anim_frame.
REQ-020 One cycle after the grant, the block asserts rsp_valid=1, rsp_id=k and rsp_bit=rom_data; latency is fixed at 1 cycle; throughput is 1 per cycle.
REQ-021 An invalid sprite id is granted normally with rom_en=0; its response has rsp_bit=0.
REQ-022 A requester keeps req high after its grant only to issue a new lookup; back-to-back grants to one requester occur only when no other requester is asserting req.
REQ-023 Animation: an 8-bit tick counter increments on frame_tick; when it reaches ANIM_DIV-1 on a tick, it wraps to 0 and anim_frame toggles.
REQ-024 On a simultaneous frame_tick and grant, the slot uses the pre-toggle anim_frame.
REQ-025 No request -> gnt=0, rom_en=0, rom_addr=0, rsp_valid=0 next cycle.

Reset
REQ-026 During rst: gnt=0, rom_en=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_bit=0, anim_frame=0, tick counter=0, rr_ptr=0.
REQ-027 A reset asserted between a grant and its response drops that response; no rsp_valid follows deassertion.
REQ-028 The first grant after reset goes to the lowest-index active requester.

Configuration
REQ-029 Macro SPRITE_ANIM_EN defined: animation per REQ-023/024.
REQ-030 SPRITE_ANIM_EN undefined: the tick counter is absent, anim_frame is held at 0, frame_tick is ignored, and pacman/ghost always use slots 2/4.

Structure
REQ-031 Shared package holds the sprite id constants, slot constants, NUM_SLOTS=14 and the tile_size default.
REQ-032 Sub-module rr_arbiter4 (req, rr_ptr -> one-hot gnt) is instantiated once; the slot mapping and response pipeline stay in the top.

Verification
REQ-033 Reset, then req=4'b0001, sprite 0, px 5 -> gnt=0001, rom_addr={0,5}, rsp_valid one cycle later with rsp_id=0 and rsp_bit=rom_data.
REQ-034 req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one rsp_valid per cycle.
REQ-035 ANIM_DIV=2, pacman px 0, four frame_ticks -> slot sequence 2,2,3,3,2 across the tick boundaries; the tick cycle uses the old frame.
REQ-036 Sprite id 13 requested -> gnt pulses, rom_en=0, rsp_bit=0.
REQ-037 rst pulsed the cycle after a grant -> no rsp_valid; anim_frame=0 and the next grant goes to the lowest active requester.
REQ-038 Build without SPRITE_ANIM_EN, 20 frame_ticks -> anim_frame stays 0; ghost id 3 always maps to slot 4.
